// File: rtl/m_final_add_pkg.sv
// Shared multiplier constants, vector-pair payload and the full-adder cell.
package m_final_add_pkg;

    localparam int unsigned MUL_WIDTH = 16;
    localparam int unsigned MUL_SPLIT = 8;

    typedef struct packed {
        logic [MUL_WIDTH-1:0] sum;
        logic [MUL_WIDTH-1:0] carry;
    } vec_pair_t;

    // One-bit full adder; returns {carry_out, sum}.
    function automatic logic [1:0] fa_cell(input logic a, input logic b, input logic cin);
        return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
    endfunction

endpackage

// File: rtl/m_final_add_if.sv
// Upstream vector-pair handshake and downstream product handshake of the final adder.
interface m_final_add_if #(
    parameter int unsigned WIDTH = m_final_add_pkg::MUL_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum_vec;
    logic [WIDTH-1:0] carry_vec;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] product;
    logic             cout;

    modport master (
        output in_valid, sum_vec, carry_vec, out_ready,
        input  in_ready, out_valid, product, cout
    );

    modport slave (
        input  in_valid, sum_vec, carry_vec, out_ready,
        output in_ready, out_valid, product, cout
    );
endinterface

// File: rtl/m_cpa_slice.sv
// N-bit ripple-carry adder slice built from the full-adder cell.
module m_cpa_slice
    import m_final_add_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    always_comb begin
        logic carry;
        sum   = '0;
        carry = cin;
        for (int i = 0; i < int'(N); i++) begin
            {carry, sum[i]} = fa_cell(a[i], b[i], carry);
        end
        cout = carry;
    end

endmodule

// File: rtl/m_final_add.sv
// Two-stage pipelined carry-propagate adder closing the tree multiplier.
module m_final_add
    import m_final_add_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH,
    parameter int unsigned SPLIT = MUL_SPLIT
) (
    input  logic          clk,
    input  logic          reset,
    m_final_add_if.slave  bus
);

    localparam int unsigned HI_W = WIDTH - SPLIT;

    logic [SPLIT-1:0] lo_sum;
    logic             lo_cout;
    logic [HI_W-1:0]  hi_sum;
    logic             hi_cout;

    logic             s1_valid;
    logic [SPLIT-1:0] s1_lo;
    logic             s1_c_mid;
    logic [HI_W-1:0]  s1_hi_s;
    logic [HI_W-1:0]  s1_hi_c;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_product;
    logic             s2_cout;

    logic s2_can_load;
    logic s1_can_load;
    logic in_fire;
    logic s1_xfer;

    m_cpa_slice #(.N(SPLIT)) u_lo (
        .a    (bus.sum_vec[SPLIT-1:0]),
        .b    (bus.carry_vec[SPLIT-1:0]),
        .cin  (1'b0),
        .sum  (lo_sum),
        .cout (lo_cout)
    );

    m_cpa_slice #(.N(HI_W)) u_hi (
        .a    (s1_hi_s),
        .b    (s1_hi_c),
        .cin  (s1_c_mid),
        .sum  (hi_sum),
        .cout (hi_cout)
    );

    // Ready chains back from out_ready so a draining pipe accepts every cycle.
    assign s2_can_load = !s2_valid || bus.out_ready;
    assign s1_can_load = !s1_valid || s2_can_load;
    assign in_fire     = bus.in_valid && s1_can_load;
    assign s1_xfer     = s1_valid && s2_can_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_lo      <= '0;
            s1_c_mid   <= 1'b0;
            s1_hi_s    <= '0;
            s1_hi_c    <= '0;
            s2_valid   <= 1'b0;
            s2_product <= '0;
            s2_cout    <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_lo    <= lo_sum;
                s1_c_mid <= lo_cout;
                s1_hi_s  <= bus.sum_vec[WIDTH-1:SPLIT];
                s1_hi_c  <= bus.carry_vec[WIDTH-1:SPLIT];
            end
            s1_valid <= in_fire || (s1_valid && !s2_can_load);

            // Output data only moves on a transfer, so it holds through stalls.
            if (s1_xfer) begin
                s2_product <= {hi_sum, s1_lo};
                s2_cout    <= hi_cout;
            end
            s2_valid <= s1_xfer || (s2_valid && !bus.out_ready);
        end
    end

    assign bus.in_ready  = s1_can_load;
    assign bus.out_valid = s2_valid;
    assign bus.product   = s2_product;
    assign bus.cout      = s2_cout;

endmodule

// File: tb/tb_m_final_add.sv
// Scoreboard bench for m_final_add: directed cases plus randomized handshake regression.
module tb_m_final_add;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic reset;

    m_final_add_if #(.WIDTH(W)) bus ();

    m_final_add #(.WIDTH(W), .SPLIT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;
    logic [W:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain modular addition with the overflow bit kept separately.
    function automatic logic [W:0] model(input logic [W-1:0] s, input logic [W-1:0] c);
        return {1'b0, s} + {1'b0, c};
    endfunction

    // Monitor: samples mid-cycle, pops on each output transfer, checks stall stability.
    initial begin
        logic             prev_stall = 1'b0;
        logic [W-1:0]     held_p = '0;
        logic             held_c = 1'b0;
        logic [W:0]       e;
        forever begin
            @(negedge clk);
            #3;
            if (!reset) begin
                if (prev_stall && bus.out_valid) begin
                    check("stall_product_stable", 32'(bus.product), 32'(held_p));
                    check("stall_cout_stable", 32'(bus.cout), 32'(held_c));
                end
                if (bus.out_valid && bus.out_ready) begin
                    n_pops++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 32'(bus.product), 32'hDEAD_BEEF);
                    end else begin
                        e = exp_q.pop_front();
                        check("product", 32'(bus.product), 32'(e[W-1:0]));
                        check("cout", 32'(bus.cout), 32'(e[W]));
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                held_p     = bus.product;
                held_c     = bus.cout;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the pair was accepted.
    task automatic send(input logic [W-1:0] s, input logic [W-1:0] c);
        int  guard = 0;
        logic acc;
        bus.in_valid  = 1'b1;
        bus.sum_vec   = s;
        bus.carry_vec = c;
        forever begin
            #3;
            acc = bus.in_ready && !reset;
            if (acc) exp_q.push_back(model(s, c));
            @(negedge clk);
            if (acc) break;
            guard++;
            if (guard > 200) begin
                check("send_timeout", 32'(0), 32'(1));
                break;
            end
        end
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.sum_vec   = W'($urandom);
        bus.carry_vec = W'($urandom);
    endtask

    task automatic drain();
        int guard = 0;
        bus.out_ready = 1'b1;
        idle();
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        check("drain_queue_empty", 32'(exp_q.size()), 32'(0));
    endtask

    // Sends one pair into an empty pipe and checks the 2-cycle latency and result.
    task automatic directed(input string name, input logic [W-1:0] s, input logic [W-1:0] c,
                            input logic [W-1:0] ep, input logic ec);
        bus.out_ready = 1'b1;
        send(s, c);
        idle();
        #3;
        check({name, "_not_early"}, 32'(bus.out_valid), 32'(0));
        @(negedge clk);
        #3;
        check({name, "_valid"}, 32'(bus.out_valid), 32'(1));
        check({name, "_product"}, 32'(bus.product), 32'(ep));
        check({name, "_cout"}, 32'(bus.cout), 32'(ec));
        @(negedge clk);
    endtask

    initial begin
        int  pops_before;
        logic saw_full;
        int  accepted;
        int  cycles;
        logic [W-1:0] rs, rc;

        reset         = 1'b1;
        bus.out_ready = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        #3;
        check("reset_out_valid", 32'(bus.out_valid), 32'(0));
        check("reset_product", 32'(bus.product), 32'(0));
        check("reset_cout", 32'(bus.cout), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        #3;
        check("reset_in_ready", 32'(bus.in_ready), 32'(1));
        @(negedge clk);

        directed("basic", 16'hFE00, 16'h0001, 16'hFE01, 1'b0);
        directed("split_carry", 16'h00FF, 16'h0001, 16'h0100, 1'b0);
        directed("overflow", 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        drain();

        // Streaming with a 4-cycle downstream stall.
        pops_before = n_pops;
        saw_full    = 1'b0;
        fork
            begin
                for (int k = 1; k <= 8; k++) send(W'(k), W'(k << 4));
                idle();
            end
            begin
                for (int cyc = 0; cyc < 10; cyc++) begin
                    bus.out_ready = !(cyc >= 3 && cyc <= 6);
                    #3;
                    if (!bus.out_ready && !bus.in_ready) saw_full = 1'b1;
                    @(negedge clk);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("stream_full_backpressure", 32'(saw_full), 32'(1));
        check("stream_output_count", 32'(n_pops - pops_before), 32'(8));

        // Reset with two results in flight; neither may ever appear.
        bus.out_ready = 1'b0;
        send(16'h1234, 16'h0101);
        send(16'h4321, 16'h1010);
        idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        #3;
        check("midreset_out_valid", 32'(bus.out_valid), 32'(0));
        check("midreset_product", 32'(bus.product), 32'(0));
        check("midreset_cout", 32'(bus.cout), 32'(0));
        check("midreset_in_ready", 32'(bus.in_ready), 32'(1));
        pops_before = n_pops;
        @(negedge clk);
        bus.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("midreset_no_stale_output", 32'(n_pops - pops_before), 32'(0));

        // Random regression with random valid/ready on both sides.
        accepted = 0;
        cycles   = 0;
        while (accepted < 10000 && cycles < 60000) begin
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            rs = W'($urandom);
            rc = W'($urandom);
            bus.sum_vec   = rs;
            bus.carry_vec = rc;
            #3;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(rs, rc));
                accepted++;
            end
            @(negedge clk);
            cycles++;
        end
        check("random_all_accepted", 32'(accepted), 32'(10000));
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/m_final_add.md
Name: m_final_add

Overview:
- Final carry-propagate stage of the tree multiplier.
- Consumes the redundant sum/carry vector pair from the last reduction stage and produces the binary product.
- Built as a 2-stage pipelined adder with valid/ready handshake on both sides, so the multiplier datapath can run at full clock rate and absorb downstream stalls.

Parameters:
- WIDTH, 16, width of the sum/carry vectors and of the product (8x8 multiplier).
- SPLIT, 8, number of low bits added in stage 1; the remaining WIDTH-SPLIT bits are added in stage 2. Legal range 1..WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream reduction stage presents a vector pair.
- in_ready  output  1  this block accepts the pair this cycle.
- sum_vec  input  WIDTH  sum vector, already column-aligned (bit i has weight 2^i).
- carry_vec  input  WIDTH  carry vector, already shifted to its column weight.
- out_valid  output  1  product is valid.
- out_ready  input  1  downstream consumer takes the product this cycle.
- product  output  WIDTH  (sum_vec + carry_vec) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1; always 0 for legal multiplier inputs, used as a check flag.

Behaviour:
- Reset: s1_valid, s2_valid, out_valid, cout = 0; product = 0; all pipeline data registers = 0.
- Stage 1 (register S1), loaded on in_valid && in_ready:
  - lo_sum = sum_vec[SPLIT-1:0] + carry_vec[SPLIT-1:0], computed SPLIT+1 bits wide.
  - S1 stores lo_sum[SPLIT-1:0], c_mid = lo_sum[SPLIT], sum_vec[WIDTH-1:SPLIT] and carry_vec[WIDTH-1:SPLIT].
- Stage 2 (register S2, drives outputs), loaded when S1 valid and S2 can accept:
  - hi_sum = hi_s + hi_c + c_mid, computed WIDTH-SPLIT+1 bits wide.
  - product = {hi_sum[WIDTH-SPLIT-1:0], lo_s}; cout = hi_sum[WIDTH-SPLIT].
- Latency: exactly 2 cycles from an accepted input to out_valid when out_ready is held high.
- Throughput: one result per cycle.
- Handshake:
  - s2_can_load = !s2_valid || out_ready.
  - s1_can_load = !s1_valid || s2_can_load.
  - in_ready = s1_can_load. It is combinational from out_ready; this chain is permitted.
  - out_valid = s2_valid.
- Holding rules:
  - While out_valid && !out_ready, product and cout hold stable.
  - S1 holds its contents if S2 cannot load.
- Valid-bit updates:
  - S1 transfers to S2 and no new input arrives: s1_valid clears.
  - New input and transfer happen in the same cycle: s1_valid stays 1 and S1 reloads.
  - Output consumed and nothing arrives from S1: s2_valid clears. Product and cout keep their last values and are don't-care while out_valid = 0.
- Full: both stages valid and out_ready = 0 gives in_ready = 0. Upstream must hold its data.
- Empty: out_valid = 0; out_ready is ignored.
- Wrap-around: the sum is modulo 2^WIDTH; overflow shows only on cout and never saturates.
- Reset mid-operation: the synchronous reset wins over any handshake in the same cycle. In-flight data is discarded, and in_ready = 1 on the cycle after reset deasserts.
- No combinational path from sum_vec/carry_vec to product.

Decomposition:
- Shared multiplier package:
  - MUL_WIDTH = 16 and MUL_SPLIT = 8 constants, used as parameter defaults here and by the reduction stages.
  - Vector-pair typedef {sum, carry} of MUL_WIDTH bits.
- One sub-module, m_cpa_slice:
  - Parameterised N-bit ripple adder with carry-in and carry-out, built from the existing FA cell.
  - Instantiated twice: N = SPLIT with cin = 0, and N = WIDTH-SPLIT with cin = c_mid.
- Pipeline registers and handshake logic stay in m_final_add.

Test Plan:
- Basic product: out_ready = 1; send sum_vec = 0xFE00, carry_vec = 0x0001 (0xFF*0xFF) → out_valid two cycles later with product = 0xFE01, cout = 0.
- Split-boundary carry: sum_vec = 0x00FF, carry_vec = 0x0001 → product = 0x0100, cout = 0. This proves c_mid propagates into stage 2.
- Overflow flag: sum_vec = 0xFFFF, carry_vec = 0x0001 → product = 0x0000, cout = 1.
- Back-to-back streaming with backpressure:
  - Send 8 consecutive pairs (k, k<<4) for k = 1..8; hold out_ready = 0 for cycles 3–6.
  - in_ready drops to 0 once both stages are full.
  - All 8 products k*17 appear in order with none lost or duplicated, and product is stable while stalled.
- Reset mid-stream: load 2 pairs, assert reset for 1 cycle → next cycle out_valid = 0, product = 0, cout = 0, in_ready = 1. Neither pre-reset result ever appears.
- Random regression: 10k random pairs with random in_valid/out_ready → product/cout equal a reference model of (sum_vec + carry_vec), in order.
